bf16_fma_arbiter: RTL and testbench

//  Shares one fixed-latency bfloat16 FMA datapath between two requesters: port 0 (Wishbone

---
 rtl/bf16_fma_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_bf16_fma_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_fma_arbiter.sv
// bf16_fma_arbiter
//   Shares one fixed-latency bfloat16 FMA datapath between two requesters.
//   Port 0 is the Wishbone front end and port 1 is the logic-analyzer front end.
//   The arbiter is round-robin. It issues at most one op per cycle, and each
//   requester may have at most one op outstanding. A 2-entry tag FIFO records
//   the owner of each in-flight op, so every result and its flags return to the
//   right response register.
//   After reset, a drain window of FMA_LATENCY cycles swallows results from ops
//   that were issued before the reset.
//
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   reqN_valid_i / reqN_ready_o       request handshake (N = 0, 1)
//   reqN_a_i, reqN_b_i, reqN_c_i      operands; the FMA computes a*b+c
//   reqN_op_i                         op code, passed through unchanged
//   respN_valid_o / respN_ready_i     held-result handshake
//   respN_result_o, respN_flags_o     result and exception flags
//   fma_valid_o                       one-cycle issue pulse to the FMA
//   fma_a_o, fma_b_o, fma_c_o,
//   fma_op_o                          registered operands and op code
//   fma_res_valid_i, fma_res_i,
//   fma_flags_i                       FMA result strobe, result and flags
//   busy_o                            an op is pending or the drain is running
//   err_o                             sticky: result strobe with no op in flight
module bf16_fma_arbiter #(
    parameter int DATA_W      = 16,
    parameter int OP_W        = 2,
    parameter int FLAG_W      = 5,
    parameter int FMA_LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [DATA_W-1:0] req0_a_i,
    input  logic [DATA_W-1:0] req0_b_i,
    input  logic [DATA_W-1:0] req0_c_i,
    input  logic [OP_W-1:0]   req0_op_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [DATA_W-1:0] req1_a_i,
    input  logic [DATA_W-1:0] req1_b_i,
    input  logic [DATA_W-1:0] req1_c_i,
    input  logic [OP_W-1:0]   req1_op_i,
    output logic              resp0_valid_o,
    input  logic              resp0_ready_i,
    output logic [DATA_W-1:0] resp0_result_o,
    output logic [FLAG_W-1:0] resp0_flags_o,
    output logic              resp1_valid_o,
    input  logic              resp1_ready_i,
    output logic [DATA_W-1:0] resp1_result_o,
    output logic [FLAG_W-1:0] resp1_flags_o,
    output logic              fma_valid_o,
    output logic [DATA_W-1:0] fma_a_o,
    output logic [DATA_W-1:0] fma_b_o,
    output logic [DATA_W-1:0] fma_c_o,
    output logic [OP_W-1:0]   fma_op_o,
    input  logic              fma_res_valid_i,
    input  logic [DATA_W-1:0] fma_res_i,
    input  logic [FLAG_W-1:0] fma_flags_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int CNT_W = $clog2(FMA_LATENCY + 1);

    // Per-port views of the flat ports, so the port logic can be generated.
    logic [1:0]        req_valid;
    logic [1:0]        resp_ready;
    logic [DATA_W-1:0] req_a [2];
    logic [DATA_W-1:0] req_b [2];
    logic [DATA_W-1:0] req_c [2];
    logic [OP_W-1:0]   req_op [2];
    logic [1:0]        pending;
    logic [1:0]        resp_valid;
    logic [DATA_W-1:0] resp_result [2];
    logic [FLAG_W-1:0] resp_flags [2];

    assign req_valid  = {req1_valid_i, req0_valid_i};
    assign resp_ready = {resp1_ready_i, resp0_ready_i};
    assign req_a[0]  = req0_a_i;
    assign req_a[1]  = req1_a_i;
    assign req_b[0]  = req0_b_i;
    assign req_b[1]  = req1_b_i;
    assign req_c[0]  = req0_c_i;
    assign req_c[1]  = req1_c_i;
    assign req_op[0] = req0_op_i;
    assign req_op[1] = req1_op_i;

    logic [CNT_W-1:0]  drain_cnt_reg;
    logic              last_grant_reg;
    logic              fma_valid_reg;
    logic [DATA_W-1:0] fma_a_reg;
    logic [DATA_W-1:0] fma_b_reg;
    logic [DATA_W-1:0] fma_c_reg;
    logic [OP_W-1:0]   fma_op_reg;
    logic              tag_mem_reg [2];
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [1:0]        fifo_cnt_reg;
    logic              err_reg;

    logic       drained;
    logic [1:0] eligible;
    logic [1:0] grant;
    logic       accept;
    logic       accept_port;
    logic       pop;
    logic       pop_tag;
    logic       spurious;

    assign drained  = (drain_cnt_reg == '0);
    // Ready depends only on the valids and on registered state, so there is
    // no combinational valid->ready loop back to the requester.
    assign eligible = req_valid & ~pending & {2{drained}};

    always_comb begin
        grant = 2'b00;
        case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_reg ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign accept      = |grant;
    assign accept_port = grant[1];

    // Results that arrive during the drain window belong to ops issued before
    // reset. They must neither pop the FIFO nor count as spurious.
    assign pop      = fma_res_valid_i & drained & (fifo_cnt_reg != 2'd0);
    assign spurious = fma_res_valid_i & drained & (fifo_cnt_reg == 2'd0);
    assign pop_tag  = tag_mem_reg[rd_ptr_reg];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drain_cnt_reg  <= CNT_W'(FMA_LATENCY);
            last_grant_reg <= 1'b1;
            fma_valid_reg  <= 1'b0;
            fma_a_reg      <= '0;
            fma_b_reg      <= '0;
            fma_c_reg      <= '0;
            fma_op_reg     <= '0;
            tag_mem_reg[0] <= 1'b0;
            tag_mem_reg[1] <= 1'b0;
            wr_ptr_reg     <= 1'b0;
            rd_ptr_reg     <= 1'b0;
            fifo_cnt_reg   <= 2'd0;
            err_reg        <= 1'b0;
        end else begin
            if (!drained) begin
                drain_cnt_reg <= drain_cnt_reg - CNT_W'(1);
            end
            fma_valid_reg <= accept;
            if (accept) begin
                fma_a_reg   <= req_a[accept_port];
                fma_b_reg   <= req_b[accept_port];
                fma_c_reg   <= req_c[accept_port];
                fma_op_reg  <= req_op[accept_port];
                last_grant_reg          <= accept_port;
                tag_mem_reg[wr_ptr_reg] <= accept_port;
                wr_ptr_reg              <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            // At most two ops can be in flight, one per port, so the count
            // never leaves 0..2 and a push and a pop may share a cycle.
            fifo_cnt_reg <= fifo_cnt_reg + {1'b0, accept} - {1'b0, pop};
            if (spurious) begin
                err_reg <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam bit PORT_ID = (gi == 1);
            logic              valid_reg;
            logic              pending_reg;
            logic [DATA_W-1:0] result_reg;
            logic [FLAG_W-1:0] flags_reg;
            logic              load;
            logic              consume;

            assign load    = pop & (pop_tag == PORT_ID);
            assign consume = valid_reg & resp_ready[gi];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    valid_reg   <= 1'b0;
                    pending_reg <= 1'b0;
                    result_reg  <= '0;
                    flags_reg   <= '0;
                end else begin
                    // A load can only reach an empty register: the port
                    // stays pending until its previous response is consumed.
                    if (load) begin
                        valid_reg  <= 1'b1;
                        result_reg <= fma_res_i;
                        flags_reg  <= fma_flags_i;
                    end else if (consume) begin
                        valid_reg <= 1'b0;
                    end
                    if (grant[gi]) begin
                        pending_reg <= 1'b1;
                    end else if (consume) begin
                        pending_reg <= 1'b0;
                    end
                end
            end

            assign pending[gi]     = pending_reg;
            assign resp_valid[gi]  = valid_reg;
            assign resp_result[gi] = result_reg;
            assign resp_flags[gi]  = flags_reg;
        end
    endgenerate

    assign req0_ready_o   = grant[0];
    assign req1_ready_o   = grant[1];
    assign resp0_valid_o  = resp_valid[0];
    assign resp1_valid_o  = resp_valid[1];
    assign resp0_result_o = resp_result[0];
    assign resp1_result_o = resp_result[1];
    assign resp0_flags_o  = resp_flags[0];
    assign resp1_flags_o  = resp_flags[1];
    assign fma_valid_o    = fma_valid_reg;
    assign fma_a_o        = fma_a_reg;
    assign fma_b_o        = fma_b_reg;
    assign fma_c_o        = fma_c_reg;
    assign fma_op_o       = fma_op_reg;
    assign err_o          = err_reg;
    // Gated by reset_n so that every output reads 0 while reset is held,
    // even though the drain counter is preloaded during reset.
    assign busy_o         = reset_n & ((|pending) | ~drained);

endmodule

// File: tb/tb_bf16_fma_arbiter.sv
// tb_bf16_fma_arbiter
//   Directed bench for bf16_fma_arbiter. A behavioural 3-cycle FMA model sits
//   behind the arbiter and answers from a small table of hand-computed bf16
//   results. The stimulus is one linear sequence of steps.
//   Timing: the FMA model updates at posedge+1. Stimulus is driven at
//   posedge+2, and outputs are checked at posedge+3.
module tb_bf16_fma_arbiter;

    logic        clk;
    logic        reset_n;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [15:0] req0_a_i, req0_b_i, req0_c_i;
    logic [15:0] req1_a_i, req1_b_i, req1_c_i;
    logic [1:0]  req0_op_i, req1_op_i;
    logic        resp0_valid_o, resp1_valid_o;
    logic        resp0_ready_i, resp1_ready_i;
    logic [15:0] resp0_result_o, resp1_result_o;
    logic [4:0]  resp0_flags_o, resp1_flags_o;
    logic        fma_valid_o;
    logic [15:0] fma_a_o, fma_b_o, fma_c_o;
    logic [1:0]  fma_op_o;
    logic        fma_res_valid_i;
    logic [15:0] fma_res_i;
    logic [4:0]  fma_flags_i;
    logic        busy_o, err_o;

    int checks   = 0;
    int failures = 0;

    bf16_fma_arbiter #(
        .DATA_W(16), .OP_W(2), .FLAG_W(5), .FMA_LATENCY(3)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_c_i(req0_c_i), .req0_op_i(req0_op_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_c_i(req1_c_i), .req1_op_i(req1_op_i),
        .resp0_valid_o(resp0_valid_o), .resp0_ready_i(resp0_ready_i),
        .resp0_result_o(resp0_result_o), .resp0_flags_o(resp0_flags_o),
        .resp1_valid_o(resp1_valid_o), .resp1_ready_i(resp1_ready_i),
        .resp1_result_o(resp1_result_o), .resp1_flags_o(resp1_flags_o),
        .fma_valid_o(fma_valid_o), .fma_a_o(fma_a_o), .fma_b_o(fma_b_o), .fma_c_o(fma_c_o),
        .fma_op_o(fma_op_o), .fma_res_valid_i(fma_res_valid_i), .fma_res_i(fma_res_i),
        .fma_flags_i(fma_flags_i), .busy_o(busy_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table-driven FMA: only the operand sets used below have real answers.
    function automatic logic [20:0] model_fma(input logic [15:0] a, input logic [15:0] b,
                                              input logic [15:0] c);
        if (a == 16'h3F80 && b == 16'h4000 && c == 16'h3F80) return {5'h00, 16'h4040}; // 1*2+1=3
        if (a == 16'h4000 && b == 16'h4000 && c == 16'h0000) return {5'h00, 16'h4080}; // 2*2+0=4
        if (a == 16'h3F80 && b == 16'h3F80 && c == 16'h3F80) return {5'h00, 16'h4000}; // 1*1+1=2
        if (a == 16'h7F80 && b == 16'h0000 && c == 16'h0000) return {5'h10, 16'h7FC0}; // inf*0 NaN
        return {5'h1F, 16'hFFFF};
    endfunction

    // The model FMA is deliberately not reset, so ops issued before a reset
    // still come back late.
    logic        p_valid [3];
    logic [20:0] p_data [3];
    logic        m_valid;
    logic [20:0] m_data;
    logic        spur_valid;
    logic [15:0] spur_res;
    logic [4:0]  spur_flags;

    initial begin
        for (int i = 0; i < 3; i++) begin
            p_valid[i] = 1'b0;
            p_data[i]  = '0;
        end
        m_valid = 1'b0;
        m_data  = '0;
    end

    always @(posedge clk) begin
        #1;
        m_valid = p_valid[2];
        m_data  = p_data[2];
        for (int i = 2; i > 0; i--) begin
            p_valid[i] = p_valid[i-1];
            p_data[i]  = p_data[i-1];
        end
        p_valid[0] = fma_valid_o;
        p_data[0]  = model_fma(fma_a_o, fma_b_o, fma_c_o);
    end

    assign fma_res_valid_i = m_valid | spur_valid;
    assign fma_res_i       = spur_valid ? spur_res : m_data[15:0];
    assign fma_flags_i     = spur_valid ? spur_flags : m_data[20:16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive0(input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [1:0] op);
        req0_valid_i = v; req0_a_i = a; req0_b_i = b; req0_c_i = c; req0_op_i = op;
    endtask

    task automatic drive1(input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [1:0] op);
        req1_valid_i = v; req1_a_i = a; req1_b_i = b; req1_c_i = c; req1_op_i = op;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    int grant_seq [16];
    int n_grants;

    initial begin
        reset_n = 1'b0;
        drive0(1'b1, 16'h3F80, 16'h4000, 16'h3F80, 2'b00);
        drive1(1'b0, 16'h0000, 16'h0000, 16'h0000, 2'b00);
        resp0_ready_i = 1'b0;
        resp1_ready_i = 1'b0;
        spur_valid = 1'b0;
        spur_res = 16'h0000;
        spur_flags = 5'h00;
        n_grants = 0;

        // ---- reset values, with req0 already valid ----
        step(); step(); settle();
        chk("rst_ready0", req0_ready_o, 0);
        chk("rst_ready1", req1_ready_o, 0);
        chk("rst_resp0_valid", resp0_valid_o, 0);
        chk("rst_resp1_valid", resp1_valid_o, 0);
        chk("rst_fma_valid", fma_valid_o, 0);
        chk("rst_fma_a", fma_a_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);

        // ---- test 1: drain window, then 1*2+1 on port 0 ----
        step(); reset_n = 1'b1; settle();
        chk("t1_drain0_ready0", req0_ready_o, 0);
        chk("t1_drain0_busy", busy_o, 1);
        step(); settle();
        chk("t1_drain1_ready0", req0_ready_o, 0);
        step(); settle();
        chk("t1_drain2_ready0", req0_ready_o, 0);
        step(); settle();                                   // cycle t: accept
        chk("t1_accept_ready0", req0_ready_o, 1);
        chk("t1_accept_ready1", req1_ready_o, 0);
        step(); req0_valid_i = 1'b0; settle();             // t+1
        chk("t1_fma_pulse", fma_valid_o, 1);
        chk("t1_fma_a", fma_a_o, 16'h3F80);
        chk("t1_fma_b", fma_b_o, 16'h4000);
        chk("t1_fma_c", fma_c_o, 16'h3F80);
        chk("t1_busy_pending", busy_o, 1);
        step(); settle();                                   // t+2
        chk("t1_fma_pulse_end", fma_valid_o, 0);
        step(); step(); settle();                           // t+4
        chk("t1_resp0_not_yet", resp0_valid_o, 0);
        step(); settle();                                   // t+5
        chk("t1_resp0_valid", resp0_valid_o, 1);
        chk("t1_resp0_result", resp0_result_o, 16'h4040);
        chk("t1_resp0_flags", resp0_flags_o, 0);
        resp0_ready_i = 1'b1;
        step(); resp0_ready_i = 1'b0; settle();
        chk("t1_resp0_consumed", resp0_valid_o, 0);
        chk("t1_idle", busy_o, 0);

        // ---- test 2: both ports request continuously ----
        // The last accept was port 0, so the first tie goes to port 1.
        step();
        drive0(1'b1, 16'h4000, 16'h4000, 16'h0000, 2'b00);
        drive1(1'b1, 16'h3F80, 16'h3F80, 16'h3F80, 2'b00);
        resp0_ready_i = 1'b1;
        resp1_ready_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            settle();
            chk("t2_single_grant", req0_ready_o & req1_ready_o, 0);
            if (req0_ready_o && n_grants < 16) begin grant_seq[n_grants] = 0; n_grants++; end
            if (req1_ready_o && n_grants < 16) begin grant_seq[n_grants] = 1; n_grants++; end
            if (resp0_valid_o) chk("t2_resp0_result", resp0_result_o, 16'h4080);
            if (resp1_valid_o) chk("t2_resp1_result", resp1_result_o, 16'h4000);
            step();
        end
        chk("t2_grant_count", n_grants, 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t2_grant_%0d", k), grant_seq[k], (k % 2 == 0) ? 1 : 0);
        end
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        repeat (6) step();
        settle();
        chk("t2_idle", busy_o, 0);
        resp0_ready_i = 1'b0;
        resp1_ready_i = 1'b0;

        // ---- test 3: port 0 response held while port 1 completes ----
        step(); drive0(1'b1, 16'h4000, 16'h4000, 16'h0000, 2'b00); settle();     // u
        chk("t3_accept0", req0_ready_o, 1);
        step(); req0_valid_i = 1'b0;
        drive1(1'b1, 16'h3F80, 16'h3F80, 16'h3F80, 2'b00); settle();            // u+1
        chk("t3_accept1", req1_ready_o, 1);
        step(); req1_valid_i = 1'b0;                                            // u+2
        step(); step(); settle();                                               // u+4
        chk("t3_resp0_not_yet", resp0_valid_o, 0);
        step(); settle();                                                       // u+5
        chk("t3_resp0_valid", resp0_valid_o, 1);
        chk("t3_resp0_result", resp0_result_o, 16'h4080);
        chk("t3_resp1_not_yet", resp1_valid_o, 0);
        step(); settle();                                                       // u+6
        chk("t3_resp1_valid", resp1_valid_o, 1);
        chk("t3_resp1_result", resp1_result_o, 16'h4000);
        resp1_ready_i = 1'b1;
        step(); resp1_ready_i = 1'b0;
        drive0(1'b1, 16'h3F80, 16'h3F80, 16'h3F80, 2'b00); settle();            // u+7
        chk("t3_resp1_consumed", resp1_valid_o, 0);
        for (int k = 0; k < 8; k++) begin
            chk("t3_resp0_held", resp0_valid_o, 1);
            chk("t3_resp0_stable", resp0_result_o, 16'h4080);
            chk("t3_no_accept_pending", req0_ready_o, 0);
            step(); settle();
        end
        resp0_ready_i = 1'b1;                                                   // u+15
        step(); resp0_ready_i = 1'b0; settle();                                 // u+16
        chk("t3_resp0_consumed", resp0_valid_o, 0);
        chk("t3_next_accept", req0_ready_o, 1);
        step(); req0_valid_i = 1'b0;                                            // u+17
        step(); step(); step(); step(); settle();                               // u+21
        chk("t3_second_resp0", resp0_valid_o, 1);
        chk("t3_second_result", resp0_result_o, 16'h4000);
        resp0_ready_i = 1'b1;
        step(); resp0_ready_i = 1'b0; settle();
        chk("t3_idle", busy_o, 0);

        // ---- test 6: resp1 handshake and req0 accept in the same cycle ----
        step(); drive1(1'b1, 16'h3F80, 16'h3F80, 16'h3F80, 2'b00); settle();    // v
        chk("t6_accept1", req1_ready_o, 1);
        step(); req1_valid_i = 1'b0;
        step(); step(); step(); step(); settle();                               // v+5
        chk("t6_resp1_valid", resp1_valid_o, 1);
        step(); resp1_ready_i = 1'b1;
        drive0(1'b1, 16'h7F80, 16'h0000, 16'h0000, 2'b10); settle();            // v+6
        chk("t6_accept0_same_cycle", req0_ready_o, 1);
        chk("t6_resp1_still_valid", resp1_valid_o, 1);
        step(); resp1_ready_i = 1'b0;
        drive1(1'b1, 16'h3F80, 16'h3F80, 16'h3F80, 2'b00); settle();            // v+7
        chk("t6_pending1_clear", req1_ready_o, 1);
        chk("t6_pending0_set", req0_ready_o, 0);
        chk("t6_resp1_gone", resp1_valid_o, 0);
        chk("t6_fma_pulse", fma_valid_o, 1);
        chk("t6_fma_op", fma_op_o, 2'b10);
        chk("t6_fma_a", fma_a_o, 16'h7F80);
        step(); req0_valid_i = 1'b0; req1_valid_i = 1'b0;                       // v+8
        step(); step(); step(); settle();                                       // v+11
        chk("t6_resp0_valid", resp0_valid_o, 1);
        chk("t6_resp0_nan", resp0_result_o, 16'h7FC0);
        chk("t6_resp0_invalid_flag", resp0_flags_o, 5'h10);
        resp0_ready_i = 1'b1;
        resp1_ready_i = 1'b1;
        step(); settle();                                                       // v+12
        chk("t6_resp1_result", resp1_result_o, 16'h4000);
        step(); settle();
        chk("t6_idle", busy_o, 0);

        // ---- test 4: reset one cycle after an accept ----
        step(); drive0(1'b1, 16'h4000, 16'h4000, 16'h0000, 2'b00); settle();    // x
        chk("t4_accept0", req0_ready_o, 1);
        step(); reset_n = 1'b0; settle();                                       // x+1
        chk("t4_rst_fma_valid", fma_valid_o, 0);
        chk("t4_rst_ready0", req0_ready_o, 0);
        chk("t4_rst_busy", busy_o, 0);
        step(); reset_n = 1'b1; settle();                                       // x+2
        chk("t4_drain0_ready0", req0_ready_o, 0);
        step(); settle();                                                       // x+3
        chk("t4_drain1_ready0", req0_ready_o, 0);
        step(); settle();                                                       // x+4: late result
        chk("t4_drain2_ready0", req0_ready_o, 0);
        step(); settle();                                                       // x+5
        chk("t4_ready_again", req0_ready_o, 1);
        chk("t4_err_clear", err_o, 0);
        chk("t4_late_dropped", resp0_valid_o, 0);
        step(); req0_valid_i = 1'b0;                                            // x+6
        step(); step(); step(); step(); settle();                               // x+10
        chk("t4_resp0_valid", resp0_valid_o, 1);
        chk("t4_resp0_result", resp0_result_o, 16'h4080);
        chk("t4_err_still_clear", err_o, 0);
        step(); settle();
        chk("t4_idle", busy_o, 0);

        // ---- test 5: spurious result with nothing in flight ----
        step(); spur_valid = 1'b1; spur_res = 16'h1234; spur_flags = 5'h1F;
        step(); spur_valid = 1'b0; settle();
        chk("t5_err_set", err_o, 1);
        chk("t5_no_resp0", resp0_valid_o, 0);
        chk("t5_no_resp1", resp1_valid_o, 0);
        step(); step(); step(); settle();
        chk("t5_err_sticky", err_o, 1);
        chk("t5_not_busy", busy_o, 0);
        step(); reset_n = 1'b0; settle();
        chk("t5_err_reset", err_o, 0);
        step(); reset_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
